key_expansion_seq: RTL and testbench

- Sequential, runtime-configurable AES key schedule engine: AES-128, AES-192 or AES-256 is selected per start.
- Generates one schedule word per cycle (or fewer, with the byte-serial S-box option) into an internal round-key store.
- Encrypt and decrypt datapaths read the store through a registered round-key port.
- Exposes a progress count so a datapath can start round 0 before expansion completes.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_sbox.sv | 30 +++
 rtl/key_expansion_seq.sv | 218 +++++++++++++++++++++
 tb/tb_key_expansion_seq.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule types, constants and helpers.
// Imported by key_expansion_seq and aes_sbox.
package aes_pkg;

    localparam int MAX_WORDS = 60;

    typedef enum logic [1:0] {
        KL_128 = 2'b00,
        KL_192 = 2'b01,
        KL_256 = 2'b10,
        KL_BAD = 2'b11
    } key_len_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_SUB
    } state_t;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            2'b00:   return 4'd4;
            2'b01:   return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'b00:   return 4'd10;
            2'b01:   return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box.
// The table is packed with entry 0 in the leftmost byte.
module aes_sbox (
    input  logic [7:0] val,
    output logic [7:0] sub
);
    import aes_pkg::*;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub = SBOX[{val, 3'b000} +: 8];

endmodule

// File: rtl/key_expansion_seq.sv
// key_expansion_seq: runtime-selectable AES-128/192/256 key schedule.
// Define KEYEXP_ZEROIZE_EN to add a zeroize input that wipes the store.
module key_expansion_seq #(
    parameter int SBOX_LANES = 4,
    parameter int MAX_WORDS  = 60
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef KEYEXP_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [0:255] key,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [3:0]   nr,
    output logic [3:0]   rounds_ready,
    input  logic [3:0]   rk_idx,
    output logic [0:127] rk_out,
    output logic         rk_valid
);
    import aes_pkg::*;

    state_t       state;
    state_t       state_nxt;
    logic [31:0]  w [MAX_WORDS];
    logic [3:0]   nk;
    logic [5:0]   i;
    logic [2:0]   kcnt;
    logic [7:0]   rcon;
    logic [1:0]   sub_cnt;
    logic [23:0]  sub_buf;

    logic         zap;
    logic         legal;
    logic         launch;
    logic         last;
    logic         rot_case;
    logic         sub_case;
    logic         wr_word;
    logic         cap;
    logic [31:0]  prev;
    logic [31:0]  old;
    logic [31:0]  sub_in;
    logic [31:0]  sub_word;
    logic [7:0]   byte_out;
    logic [31:0]  temp;
    logic [31:0]  new_word;
    logic [3:0]   nk_new;
    logic [5:0]   base;

`ifdef KEYEXP_ZEROIZE_EN
    assign zap = zeroize;
`else
    assign zap = 1'b0;
`endif

    assign legal    = (key_len != KL_BAD);
    assign launch   = (state == ST_IDLE) && start && !zap;
    assign nk_new   = nk_of(key_len);
    assign last     = (i == {nr, 2'b11});
    assign prev     = w[i - 6'd1];
    assign old      = w[i - {2'b00, nk}];
    assign rot_case = (kcnt == 3'd0);
    assign sub_case = rot_case || (nk == 4'd8 && kcnt == 3'd4);
    assign sub_in   = rot_case ? rot_word(prev) : prev;
    assign base     = {rk_idx, 2'b00};

    generate
        if (SBOX_LANES == 1) begin : g_serial
            logic [7:0] lane_in;
            logic [7:0] lane_out;
            // byte 0 is the most significant byte of the word
            assign lane_in = sub_in[{~sub_cnt, 3'b000} +: 8];
            aes_sbox u_sbox (
                .val(lane_in),
                .sub(lane_out)
            );
            assign byte_out = lane_out;
            assign sub_word = {sub_buf, lane_out};
        end else begin : g_par
            for (genvar k = 0; k < 4; k++) begin : g_lane
                aes_sbox u_sbox (
                    .val(sub_in[8*k +: 8]),
                    .sub(sub_word[8*k +: 8])
                );
            end
            assign byte_out = sub_word[31:24];
        end
    endgenerate

    always_comb begin
        temp = prev;
        if (rot_case) begin
            temp = sub_word ^ {rcon, 24'h000000};
        end else if (sub_case) begin
            temp = sub_word;
        end
    end

    assign new_word = old ^ temp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start && legal) state_nxt = ST_GEN;
            end
            ST_GEN: begin
                if (!wr_word) state_nxt = ST_SUB;
                else if (last) state_nxt = ST_IDLE;
            end
            ST_SUB: begin
                if (wr_word) state_nxt = last ? ST_IDLE : ST_GEN;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (zap) state_nxt = ST_IDLE;
    end

    always_comb begin
        busy    = 1'b0;
        wr_word = 1'b0;
        cap     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_GEN: begin
                busy = 1'b1;
                if (sub_case && SBOX_LANES == 1) cap = 1'b1;
                else wr_word = 1'b1;
            end
            ST_SUB: begin
                busy = 1'b1;
                if (sub_cnt == 2'd3) wr_word = 1'b1;
                else cap = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_WORDS; k++) w[k] <= '0;
            nk           <= '0;
            nr           <= '0;
            i            <= '0;
            kcnt         <= '0;
            rcon         <= 8'h01;
            sub_cnt      <= '0;
            sub_buf      <= '0;
            rounds_ready <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            rk_out       <= '0;
            rk_valid     <= 1'b0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            rk_valid <= (rk_idx < rounds_ready) && (rk_idx <= nr);
            if (rk_idx == 4'd15) begin
                rk_out <= '0;
            end else begin
                rk_out <= {w[base], w[base + 6'd1],
                           w[base + 6'd2], w[base + 6'd3]};
            end
            if (zap) begin
                for (int k = 0; k < MAX_WORDS; k++) w[k] <= '0;
                rk_out       <= '0;
                rk_valid     <= 1'b0;
                rounds_ready <= '0;
                sub_cnt      <= '0;
            end else if (launch) begin
                if (!legal) begin
                    err <= 1'b1;
                end else begin
                    nk           <= nk_new;
                    nr           <= nr_of(key_len);
                    i            <= {2'b00, nk_new};
                    kcnt         <= '0;
                    rcon         <= 8'h01;
                    sub_cnt      <= '0;
                    rounds_ready <= nk_new >> 2;
                    for (int k = 0; k < 8; k++) begin
                        if (k < int'(nk_new)) w[k] <= key[32*k +: 32];
                    end
                end
            end else begin
                if (cap) begin
                    sub_buf <= {sub_buf[15:0], byte_out};
                    sub_cnt <= sub_cnt + 2'd1;
                end
                if (wr_word) begin
                    w[i]    <= new_word;
                    i       <= i + 6'd1;
                    sub_cnt <= '0;
                    kcnt    <= ({1'b0, kcnt} == nk - 4'd1) ? 3'd0 : kcnt + 3'd1;
                    if (rot_case) rcon <= xtime(rcon);
                    // a round key is complete once its 4th word lands
                    if (i[1:0] == 2'b11) rounds_ready <= i[5:2] + 4'd1;
                    if (last) done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_expansion_seq.sv
// tb_key_expansion_seq: directed FIPS-197 vectors for key_expansion_seq.
// Instance a uses 4 S-box lanes, instance b is byte-serial.
module tb_key_expansion_seq;

    localparam logic [0:127] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] KSEQ = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] RSEQ = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [0:191] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [0:255] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_a, start_b;
    logic [1:0]   key_len_a, key_len_b;
    logic [0:255] key_a, key_b;
    logic [3:0]   rk_idx_a, rk_idx_b;
    logic         busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [3:0]   nr_a, nr_b, rr_a, rr_b;
    logic [0:127] rk_out_a, rk_out_b;
    logic         rk_valid_a, rk_valid_b;
`ifdef KEYEXP_ZEROIZE_EN
    logic         zeroize;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    key_expansion_seq u_a (
        .clk(clk), .rst_n(rst_n),
`ifdef KEYEXP_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .start(start_a), .key_len(key_len_a), .key(key_a),
        .busy(busy_a), .done(done_a), .err(err_a), .nr(nr_a),
        .rounds_ready(rr_a), .rk_idx(rk_idx_a),
        .rk_out(rk_out_a), .rk_valid(rk_valid_a)
    );

    key_expansion_seq #(.SBOX_LANES(1)) u_b (
        .clk(clk), .rst_n(rst_n),
`ifdef KEYEXP_ZEROIZE_EN
        .zeroize(1'b0),
`endif
        .start(start_b), .key_len(key_len_b), .key(key_b),
        .busy(busy_b), .done(done_b), .err(err_b), .nr(nr_b),
        .rounds_ready(rr_b), .rk_idx(rk_idx_b),
        .rk_out(rk_out_b), .rk_valid(rk_valid_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit sel, output int n);
        n = -1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if ((sel ? done_b : done_a) === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic go_a(input logic [1:0] kl, input logic [0:255] k);
        key_len_a = kl;
        key_a     = k;
        start_a   = 1'b1;
        tick();
        start_a   = 1'b0;
    endtask

    task automatic rd_a(input logic [3:0] idx);
        rk_idx_a = idx;
        tick();
    endtask

    task automatic rd_b(input logic [3:0] idx);
        rk_idx_b = idx;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        key_len_a = 2'b00; key_len_b = 2'b00;
        key_a = '0; key_b = '0;
        rk_idx_a = 4'd0; rk_idx_b = 4'd0;
`ifdef KEYEXP_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        #12;
        vecs++;
        if ({busy_a, done_a, err_a, nr_a, rr_a, rk_valid_a} !== 12'h0) begin
            errs++;
            $display("FAIL reset_flags got %h want 0",
                     {busy_a, done_a, err_a, nr_a, rr_a, rk_valid_a});
        end
        vecs++;
        if (rk_out_a !== '0) begin
            errs++;
            $display("FAIL reset_rk got %h want 0", rk_out_a);
        end
        rst_n = 1'b1;
        rd_a(4'd0);
        vecs++;
        if (rk_out_a !== '0 || rk_valid_a !== 1'b0) begin
            errs++;
            $display("FAIL reset_read got %h/%b want 0/0", rk_out_a, rk_valid_a);
        end
    endtask

    task automatic test_aes128();
        int n;
        go_a(2'b00, {K128, 128'h0});
        vecs++;
        if (busy_a !== 1'b1 || rr_a !== 4'd1) begin
            errs++;
            $display("FAIL a128_start got busy=%b rr=%0d want 1/1", busy_a, rr_a);
        end
        wait_done(1'b0, n);
        vecs++;
        if (n !== 40) begin
            errs++;
            $display("FAIL a128_latency got %0d want 40", n);
        end
        vecs++;
        if (busy_a !== 1'b0 || nr_a !== 4'd10 || rr_a !== 4'd11) begin
            errs++;
            $display("FAIL a128_end got busy=%b nr=%0d rr=%0d want 0/10/11",
                     busy_a, nr_a, rr_a);
        end
        rd_a(4'd10);
        vecs++;
        if (done_a !== 1'b0) begin
            errs++;
            $display("FAIL a128_done_pulse got %b want 0", done_a);
        end
        vecs++;
        if (rk_out_a !== R10 || rk_valid_a !== 1'b1) begin
            errs++;
            $display("FAIL a128_rk10 got %h/%b want %h/1", rk_out_a, rk_valid_a, R10);
        end
        rd_a(4'd1);
        vecs++;
        if (rk_out_a[0:31] !== 32'ha0fafe17) begin
            errs++;
            $display("FAIL a128_w4 got %h want a0fafe17", rk_out_a[0:31]);
        end
        rd_a(4'd0);
        vecs++;
        if (rk_out_a !== K128) begin
            errs++;
            $display("FAIL a128_rk0 got %h want %h", rk_out_a, K128);
        end
        rd_a(4'd11);
        vecs++;
        if (rk_valid_a !== 1'b0) begin
            errs++;
            $display("FAIL a128_rk11_valid got %b want 0", rk_valid_a);
        end
        rd_a(4'd15);
        vecs++;
        if (rk_out_a !== '0 || rk_valid_a !== 1'b0) begin
            errs++;
            $display("FAIL a128_rk15 got %h/%b want 0/0", rk_out_a, rk_valid_a);
        end
    endtask

    task automatic test_aes192();
        int n;
        go_a(2'b01, {K192, 64'h0});
        wait_done(1'b0, n);
        vecs++;
        if (n !== 46 || nr_a !== 4'd12) begin
            errs++;
            $display("FAIL a192_end got n=%0d nr=%0d want 46/12", n, nr_a);
        end
        rd_a(4'd1);
        vecs++;
        if (rk_out_a[64:95] !== 32'hfe0c91f7) begin
            errs++;
            $display("FAIL a192_w6 got %h want fe0c91f7", rk_out_a[64:95]);
        end
        rd_a(4'd12);
        vecs++;
        if (rk_out_a[96:127] !== 32'h01002202 || rk_valid_a !== 1'b1) begin
            errs++;
            $display("FAIL a192_w51 got %h/%b want 01002202/1",
                     rk_out_a[96:127], rk_valid_a);
        end
    endtask

    task automatic test_aes256_serial();
        int n;
        bit mono;
        logic [3:0] prev;
        key_len_b = 2'b10;
        key_b     = K256;
        start_b   = 1'b1;
        tick();
        start_b   = 1'b0;
        vecs++;
        if (rr_b !== 4'd2) begin
            errs++;
            $display("FAIL a256_rr_start got %0d want 2", rr_b);
        end
        mono = 1'b1;
        prev = rr_b;
        n = -1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (rr_b < prev || rr_b > prev + 4'd1) mono = 1'b0;
            prev = rr_b;
            if (done_b === 1'b1) begin
                n = c;
                break;
            end
        end
        vecs++;
        if (n !== 91 || rr_b !== 4'd15) begin
            errs++;
            $display("FAIL a256_end got n=%0d rr=%0d want 91/15", n, rr_b);
        end
        vecs++;
        if (mono !== 1'b1) begin
            errs++;
            $display("FAIL a256_rr_steps got %b want 1", mono);
        end
        rd_b(4'd2);
        vecs++;
        if (rk_out_b[0:31] !== 32'h9ba35411) begin
            errs++;
            $display("FAIL a256_w8 got %h want 9ba35411", rk_out_b[0:31]);
        end
        rd_b(4'd14);
        vecs++;
        if (rk_out_b[96:127] !== 32'h706c631e || rk_valid_b !== 1'b1) begin
            errs++;
            $display("FAIL a256_w59 got %h/%b want 706c631e/1",
                     rk_out_b[96:127], rk_valid_b);
        end
    endtask

    task automatic test_aes128_serial();
        int n;
        key_len_b = 2'b00;
        key_b     = {K128, 128'h0};
        start_b   = 1'b1;
        tick();
        start_b   = 1'b0;
        wait_done(1'b1, n);
        vecs++;
        if (n !== 70) begin
            errs++;
            $display("FAIL s128_latency got %0d want 70", n);
        end
        rd_b(4'd10);
        vecs++;
        if (rk_out_b !== R10) begin
            errs++;
            $display("FAIL s128_rk10 got %h want %h", rk_out_b, R10);
        end
    endtask

    task automatic test_err();
        go_a(2'b11, {K128, 128'h0});
        vecs++;
        if (err_a !== 1'b1 || busy_a !== 1'b0) begin
            errs++;
            $display("FAIL err_pulse got err=%b busy=%b want 1/0", err_a, busy_a);
        end
        vecs++;
        if (nr_a !== 4'd12 || rr_a !== 4'd13) begin
            errs++;
            $display("FAIL err_hold got nr=%0d rr=%0d want 12/13", nr_a, rr_a);
        end
        tick();
        vecs++;
        if (err_a !== 1'b0 || busy_a !== 1'b0) begin
            errs++;
            $display("FAIL err_clear got err=%b busy=%b want 0/0", err_a, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        go_a(2'b00, {K128, 128'h0});
        repeat (5) tick();
        go_a(2'b10, K256);
        vecs++;
        if (err_a !== 1'b0 || busy_a !== 1'b1) begin
            errs++;
            $display("FAIL b2b_ignore got err=%b busy=%b want 0/1", err_a, busy_a);
        end
        wait_done(1'b0, n);
        vecs++;
        if (n !== 34 || nr_a !== 4'd10) begin
            errs++;
            $display("FAIL b2b_end got n=%0d nr=%0d want 34/10", n, nr_a);
        end
        rd_a(4'd10);
        vecs++;
        if (rk_out_a !== R10) begin
            errs++;
            $display("FAIL b2b_rk10 got %h want %h", rk_out_a, R10);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit saw;
        go_a(2'b00, {KSEQ, 128'h0});
        repeat (19) tick();
        rst_n = 1'b0;
        #2;
        vecs++;
        if ({busy_a, done_a, err_a, nr_a, rr_a, rk_valid_a} !== 12'h0
            || rk_out_a !== '0) begin
            errs++;
            $display("FAIL rstmid_clear got %h/%h want 0/0",
                     {busy_a, done_a, err_a, nr_a, rr_a, rk_valid_a}, rk_out_a);
        end
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (30) begin
            tick();
            if (done_a !== 1'b0 || busy_a !== 1'b0) saw = 1'b1;
        end
        vecs++;
        if (saw !== 1'b0) begin
            errs++;
            $display("FAIL rstmid_quiet got %b want 0", saw);
        end
        go_a(2'b00, {KSEQ, 128'h0});
        wait_done(1'b0, n);
        rd_a(4'd10);
        vecs++;
        if (n !== 40 || rk_out_a !== RSEQ) begin
            errs++;
            $display("FAIL rstmid_rk10 got n=%0d %h want 40 %h", n, rk_out_a, RSEQ);
        end
    endtask

`ifdef KEYEXP_ZEROIZE_EN
    task automatic test_zeroize();
        bit saw;
        rk_idx_a = 4'd0;
        go_a(2'b00, {K128, 128'h0});
        repeat (14) tick();
        zeroize = 1'b1;
        start_a = 1'b1;
        tick();
        zeroize = 1'b0;
        start_a = 1'b0;
        vecs++;
        if (rr_a !== 4'd0 || busy_a !== 1'b0 || rk_out_a !== '0) begin
            errs++;
            $display("FAIL zero_clear got rr=%0d busy=%b rk=%h want 0/0/0",
                     rr_a, busy_a, rk_out_a);
        end
        saw = 1'b0;
        repeat (40) begin
            tick();
            if (done_a !== 1'b0) saw = 1'b1;
        end
        vecs++;
        if (saw !== 1'b0) begin
            errs++;
            $display("FAIL zero_nodone got %b want 0", saw);
        end
        rd_a(4'd0);
        vecs++;
        if (rk_out_a !== '0 || rk_valid_a !== 1'b0) begin
            errs++;
            $display("FAIL zero_read got %h/%b want 0/0", rk_out_a, rk_valid_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256_serial();
        test_aes128_serial();
        test_err();
        test_back_to_back();
        test_reset_mid();
`ifdef KEYEXP_ZEROIZE_EN
        test_zeroize();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
